// File: rtl/reg_mem_pkg.sv
// Shared types and the test-pattern function for the reg_mem BIST initiator.
// Used by reg_mem_bist (optional macro BIST_INV_PASS_EN) and bist_cmp_pipe.
package reg_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } bist_state_t;

    localparam int PAT_W = 32;

    // The caller truncates to its word width; truncation gives the mod 2**DATA_WIDTH wrap.
    function automatic logic [PAT_W-1:0] pattern(
        input logic [PAT_W-1:0] seed,
        input logic [PAT_W-1:0] addr,
        input logic             inv
    );
        logic [PAT_W-1:0] p;
        p = seed + addr;
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/bist_cmp_pipe.sv
// Read-compare pipe: delays {valid, addr, expected} by RD_LAT cycles so each entry
// lines up with reg_mem data_out, then flags a mismatch for that address.
module bist_cmp_pipe
    import reg_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [ADDR_BITS-1:0]  in_addr,
    input  logic [DATA_WIDTH-1:0] in_exp,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  mismatch,
    output logic [ADDR_BITS-1:0]  mismatch_addr
);

    logic                  out_valid;
    logic [ADDR_BITS-1:0]  out_addr;
    logic [DATA_WIDTH-1:0] out_exp;

    generate
        if (RD_LAT == 0) begin : g_comb
            always_comb begin
                out_valid = in_valid;
                out_addr  = in_addr;
                out_exp   = in_exp;
            end
        end else begin : g_pipe
            logic [RD_LAT-1:0]     vld_q, vld_d;
            logic [ADDR_BITS-1:0]  addr_q [RD_LAT];
            logic [ADDR_BITS-1:0]  addr_d [RD_LAT];
            logic [DATA_WIDTH-1:0] exp_q  [RD_LAT];
            logic [DATA_WIDTH-1:0] exp_d  [RD_LAT];

            // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
            always_comb begin
                vld_d[0]  = in_valid;
                addr_d[0] = in_addr;
                exp_d[0]  = in_exp;
                for (int i = 1; i < RD_LAT; i++) begin
                    vld_d[i]  = vld_q[i-1];
                    addr_d[i] = addr_q[i-1];
                    exp_d[i]  = exp_q[i-1];
                end
            end

            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            // NOTE: only the valid bits need reset; payload stages are ignored while invalid.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                end else begin
                    vld_q <= vld_d;
                end
                addr_q <= addr_d;
                exp_q  <= exp_d;
            end

            assign out_valid = vld_q[RD_LAT-1];
            assign out_addr  = addr_q[RD_LAT-1];
            assign out_exp   = exp_q[RD_LAT-1];
        end
    endgenerate

    always_comb begin
        mismatch      = out_valid && (rdata != out_exp);
        mismatch_addr = out_addr;
    end

endmodule

// File: rtl/reg_mem_bist.sv
// Write/read-back BIST initiator for reg_mem. Define BIST_INV_PASS_EN to add a second
// pass using the complemented pattern; errors accumulate across both passes.
module reg_mem_bist
    import reg_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_BITS+1:0]  err_count,
    output logic [ADDR_BITS-1:0]  first_err_addr,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_BITS-1:0] ADDR_LAST  = '1;
    localparam logic [1:0]           DRAIN_LAST = 2'(RD_LAT - 1);

    function automatic logic [DATA_WIDTH-1:0] pat(
        input logic [ADDR_BITS-1:0]  a,
        input logic [DATA_WIDTH-1:0] s,
        input logic                  inv
    );
        return DATA_WIDTH'(pattern(PAT_W'(s), PAT_W'(a), inv));
    endfunction

    bist_state_t           state_q, state_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic [ADDR_BITS+1:0]  err_count_q, err_count_d;
    logic [ADDR_BITS-1:0]  first_err_q, first_err_d;
    logic                  pass_q, pass_d;
    logic [1:0]            drain_cnt_q, drain_cnt_d;

    logic                  inv_cur;
    logic                  rd_push;
    logic                  pass_end;
    logic [DATA_WIDTH-1:0] rd_exp;
    logic                  mismatch;
    logic [ADDR_BITS-1:0]  mismatch_addr;

`ifdef BIST_INV_PASS_EN
    logic inv_q, inv_d;
    assign inv_cur = inv_q;
`else
    assign inv_cur = 1'b0;
`endif

    assign rd_exp = pat(addr_q, seed_q, inv_cur);

    bist_cmp_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS),
        .RD_LAT     (RD_LAT)
    ) u_cmp_pipe (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (rd_push),
        .in_addr       (addr_q),
        .in_exp        (rd_exp),
        .rdata         (mem_rdata),
        .mismatch      (mismatch),
        .mismatch_addr (mismatch_addr)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        seed_d      = seed_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;
        drain_cnt_d = drain_cnt_q;
`ifdef BIST_INV_PASS_EN
        inv_d       = inv_q;
`endif
        rd_push     = 1'b0;
        pass_end    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    seed_d      = seed;
                    err_count_d = '0;
                    first_err_d = '0;
                    pass_d      = 1'b0;
                    state_d     = WRITE;
                    addr_d      = '0;
                    wen_d       = 1'b1;
                    wdata_d     = pat('0, seed, 1'b0);
`ifdef BIST_INV_PASS_EN
                    inv_d       = 1'b0;
`endif
                end
            end
            WRITE: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = READ;
                    addr_d  = '0;
                    wen_d   = 1'b0;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    wdata_d = pat(addr_q + 1'b1, seed_q, inv_cur);
                end
            end
            READ: begin
                rd_push = 1'b1;
                if (addr_q == ADDR_LAST) begin
                    addr_d = '0;
                    if (RD_LAT == 0) begin
                        pass_end = 1'b1;
                    end else begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    pass_end = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The pipe is empty by the end of a pass, so a second pass can start immediately.
        if (pass_end) begin
`ifdef BIST_INV_PASS_EN
            if (!inv_q) begin
                inv_d   = 1'b1;
                state_d = WRITE;
                addr_d  = '0;
                wen_d   = 1'b1;
                wdata_d = pat('0, seed_q, 1'b1);
            end else begin
                state_d = DONE;
            end
`else
            state_d = DONE;
`endif
        end

        if (mismatch) begin
            if (err_count_q == '0) begin
                first_err_d = mismatch_addr;
            end
            if (err_count_q != '1) begin
                err_count_d = err_count_q + 1'b1;
            end
        end

        // The last compare can land on the same edge that enters DONE.
        if ((state_d == DONE) && (state_q != DONE)) begin
            pass_d = (err_count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            seed_q      <= '0;
            err_count_q <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
            drain_cnt_q <= '0;
`ifdef BIST_INV_PASS_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            seed_q      <= seed_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
            drain_cnt_q <= drain_cnt_d;
`ifdef BIST_INV_PASS_EN
            inv_q       <= inv_d;
`endif
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wen        = wen_q;

endmodule

// File: tb/tb_reg_mem_bist.sv
// Bench for reg_mem_bist: a faultable reg_mem model plus an arithmetic reference of the
// expected write stream, completion cycle and error results.
module tb_reg_mem_bist;

    localparam int DW = 8;
    localparam int AB = 5;
    localparam int RL = 1;
    localparam int N  = 1 << AB;
    localparam int EW = AB + 2;
`ifdef BIST_INV_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] seed;
    logic          busy;
    logic          done;
    logic          pass;
    logic [EW-1:0] err_count;
    logic [AB-1:0] first_err_addr;
    logic [AB-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wen;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Fault model: f_addr == N means every address.
    bit f_en  = 1'b0;
    int f_addr = 0;
    int f_bit  = 0;
    bit f_val  = 1'b0;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] rd_q;

    reg_mem_bist #(
        .DATA_WIDTH (DW),
        .ADDR_BITS  (AB),
        .RD_LAT     (RL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wen        (mem_wen),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input int a);
        logic [DW-1:0] r;
        r = v;
        if (f_en && (f_addr == N || f_addr == a)) r[f_bit] = f_val;
        return r;
    endfunction

    // reg_mem with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        rd_q <= faulty(mem[mem_addr], int'(mem_addr));
    end
    assign mem_rdata = rd_q;

    function automatic logic [DW-1:0] exp_pat(input logic [DW-1:0] s, input int a, input int p);
        int v;
        v = (int'(s) + a) % (1 << DW);
        if (p != 0) v = (1 << DW) - 1 - v;
        return DW'(v);
    endfunction

    task automatic run_and_check(input string name, input logic [DW-1:0] s, input int glitch);
        int  exp_err   = 0;
        int  exp_first = 0;
        bit  got_first = 1'b0;
        bit  exp_pass;
        int  done_cyc;
        int  done_seen = 0;
        bit  exp_wen;
        int  exp_addr;
        logic [DW-1:0] exp_data;
        for (int p = 0; p < PASSES; p++) begin
            for (int a = 0; a < N; a++) begin
                if (faulty(exp_pat(s, a, p), a) !== exp_pat(s, a, p)) begin
                    exp_err++;
                    if (!got_first) begin
                        got_first = 1'b1;
                        exp_first = a;
                    end
                end
            end
        end
        if (exp_err > (1 << EW) - 1) exp_err = (1 << EW) - 1;
        exp_pass = (exp_err == 0);
        done_cyc = PASSES * (2 * N + RL) + 1;

        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= done_cyc + 2; n++) begin
            @(negedge clk);
            if (n == glitch) begin
                start = 1'b1;
                seed  = ~s;
            end else begin
                start = 1'b0;
                seed  = s;
            end
            exp_wen  = 1'b0;
            exp_addr = 0;
            exp_data = '0;
            for (int p = 0; p < PASSES; p++) begin
                int rel;
                rel = n - 1 - p * (2 * N + RL);
                if (rel >= 0 && rel < N) begin
                    exp_wen  = 1'b1;
                    exp_addr = rel;
                    exp_data = exp_pat(s, rel, p);
                end else if (rel >= N && rel < 2 * N) begin
                    exp_addr = rel - N;
                end
            end
            n_checks++;
            if ({mem_wen, mem_addr, busy, done} !== {exp_wen, AB'(exp_addr), (n <= done_cyc), (n == done_cyc)}) begin
                n_fail++;
                $display("FAIL %s cyc%0d wen/addr/busy/done got %0b/%0d/%0b/%0b exp %0b/%0d/%0b/%0b",
                         name, n, mem_wen, mem_addr, busy, done,
                         exp_wen, exp_addr, (n <= done_cyc), (n == done_cyc));
            end
            if (exp_wen) begin
                n_checks++;
                if (mem_wdata !== exp_data) begin
                    n_fail++;
                    $display("FAIL %s cyc%0d wdata got %0h exp %0h", name, n, mem_wdata, exp_data);
                end
            end
            if (done === 1'b1) done_seen++;
            if (n == done_cyc) begin
                n_checks++;
                if ({pass, err_count, first_err_addr} !== {exp_pass, EW'(exp_err), AB'(exp_first)}) begin
                    n_fail++;
                    $display("FAIL %s result pass/err/first got %0b/%0d/%0d exp %0b/%0d/%0d",
                             name, pass, err_count, first_err_addr, exp_pass, exp_err, exp_first);
                end
            end
        end
        n_checks++;
        if (done_seen != 1 || pass !== exp_pass) begin
            n_fail++;
            $display("FAIL %s done_count/held_pass got %0d/%0b exp 1/%0b", name, done_seen, pass, exp_pass);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        seed  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy, done, pass, err_count, first_err_addr, mem_addr, mem_wdata, mem_wen} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs got busy=%0b done=%0b pass=%0b err=%0d first=%0d addr=%0d wdata=%0h wen=%0b exp all 0",
                     busy, done, pass, err_count, first_err_addr, mem_addr, mem_wdata, mem_wen);
        end
    endtask

    task automatic test_fault_free();
        f_en = 1'b0;
        run_and_check("fault_free_seed10", 8'd10, 0);
    endtask

    task automatic test_stuck_bit();
        f_en = 1'b1; f_addr = 12; f_bit = 3; f_val = 1'b0;
        run_and_check("stuck_bit3_addr12", 8'd0, 0);
        f_en = 1'b0;
    endtask

    task automatic test_seed_wrap();
        run_and_check("seed_wrap_f0", 8'hF0, 0);
    endtask

    task automatic test_mid_reset();
        f_en = 1'b1; f_addr = N; f_bit = 0; f_val = 1'b1;
        @(negedge clk);
        seed  = 8'd0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        // Cycle 40: addresses 0..5 have been compared; evens 0, 2, 4 fail.
        n_checks++;
        if (err_count !== EW'(3) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset pre err/busy got %0d/%0b exp 3/1", err_count, busy);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({mem_wen, busy, done, pass, err_count, first_err_addr, mem_addr} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset post wen=%0b busy=%0b done=%0b pass=%0b err=%0d first=%0d addr=%0d exp all 0",
                     mem_wen, busy, done, pass, err_count, first_err_addr, mem_addr);
        end
        f_en = 1'b0;
        run_and_check("after_mid_reset", 8'h5A, 0);
    endtask

    task automatic test_start_while_busy();
        run_and_check("start_while_busy", 8'd10, 20);
    endtask

    task automatic test_inv_pass();
        f_en = 1'b1; f_addr = N; f_bit = 0; f_val = 1'b1;
        run_and_check("bit0_sa1_all", 8'd0, 0);
        f_en = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            f_en   = 1'($urandom_range(0, 1));
            f_addr = int'($urandom_range(0, N));
            f_bit  = int'($urandom_range(0, DW - 1));
            f_val  = 1'($urandom_range(0, 1));
            run_and_check($sformatf("random_%0d", i), DW'($urandom_range(0, (1 << DW) - 1)), 0);
        end
        f_en = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        seed  = '0;
        test_reset();
        test_fault_free();
        test_stuck_bit();
        test_seed_wrap();
        test_mid_reset();
        test_start_while_busy();
        test_inv_pass();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
